data_mem_sized: RTL and testbench

Parametrised successor to the single-cycle data memory. Adds byte/halfword/word load-store with sign or zero extension, misalignment detection with a sticky fault capture, and a post-reset clear sequencer. Sits in the MEM stage of the single-cycle MIPS datapath: the ALU result drives the address, and the loaded value feeds the write-back mux.

---
 rtl/data_mem_sized.sv | 150 +++++++++++++++
 tb/tb_data_mem_sized.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sized.sv
// Byte/half/word data memory for the MEM stage, with sign/zero-extending
// loads, misalignment detection, sticky fault capture and post-reset clear.
module data_mem_sized #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic              fault_clr,
    output logic [DATA_W-1:0] r_data,
    output logic              misaligned,
    output logic              busy,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_W / 8;

    typedef enum logic {CLEAR, IDLE} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [1:0]        off;
    logic              bad;
    logic              st_en;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] ld_v;

    assign idx = addr[IDX_W+1:2];
    assign off = addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) state_d = IDLE;
        end
    end

    always_comb begin
        busy = (state_q == CLEAR);
    end

    always_comb begin
        unique case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
    end

    assign misaligned = (read_en | write_en) & bad & ~busy;
    assign st_en      = write_en & ~busy & ~misaligned;

    // Sub-word data is replicated across lanes; be picks the live ones.
    always_comb begin
        be = '0;
        wd = w_data;
        unique case (size)
            2'b00: begin
                be = NB'(1) << off;
                wd = {NB{w_data[7:0]}};
            end
            2'b01: begin
                be = off[1] ? 4'b1100 : 4'b0011;
                wd = {(NB/2){w_data[15:0]}};
            end
            2'b10:   be = '1;
            default: be = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[ptr_q] <= '0;
        end else if (st_en) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign word   = mem_q[idx];
    assign byte_v = word[{off, 3'b000} +: 8];
    assign half_v = word[{off[1], 4'b0000} +: 16];

    always_comb begin
        unique case (size)
            2'b00:   ld_v = {{(DATA_W-8){~unsigned_ld & byte_v[7]}}, byte_v};
            2'b01:   ld_v = {{(DATA_W-16){~unsigned_ld & half_v[15]}}, half_v};
            2'b10:   ld_v = word;
            default: ld_v = '0;
        endcase
    end

    assign r_data = (read_en & ~busy & ~misaligned) ? ld_v : '0;

    // A clear in the same cycle as a new fault wins over the capture.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (fault_clr) begin
            fault_d = 1'b0;
        end else if (misaligned && !fault_q) begin
            fault_d      = 1'b1;
            fault_addr_d = addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
endmodule

// File: tb/tb_data_mem_sized.sv
// Scoreboard bench for data_mem_sized: clear sequence, sized
// loads/stores, misalignment, sticky fault, wrap and mid-clear reset.
module tb_data_mem_sized;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        write_en;
    logic        read_en;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic        fault_clr;
    logic [31:0] r_data;
    logic        misaligned;
    logic        busy;
    logic        fault;
    logic [31:0] fault_addr;

    int n_chk  = 0;
    int n_pass = 0;
    int ncyc;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    data_mem_sized #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .addr(addr), .w_data(w_data),
        .write_en(write_en), .read_en(read_en), .size(size),
        .unsigned_ld(unsigned_ld), .fault_clr(fault_clr),
        .r_data(r_data), .misaligned(misaligned), .busy(busy),
        .fault(fault), .fault_addr(fault_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] exp);
        addr        = a;
        size        = sz;
        unsigned_ld = u;
        write_en    = 1'b0;
        read_en     = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        chk($sformatf("ld@%0h/s%0d/u%0d", a, sz, u), r_data,
            exp_q.pop_front());
        @(posedge clk);
        #1;
        read_en = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz);
        addr     = a;
        w_data   = d;
        size     = sz;
        read_en  = 1'b0;
        write_en = 1'b1;
        @(posedge clk);
        #1;
        write_en = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 10) begin
                read_en = 1'b1;
                exp_q.push_back(32'h0);
                #1;
                chk("busy_rd", r_data, exp_q.pop_front());
                read_en = 1'b0;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        addr        = 32'h0;
        w_data      = 32'hFFFF_FFFF;
        write_en    = 1'b1;
        read_en     = 1'b0;
        size        = 2'b10;
        unsigned_ld = 1'b0;
        fault_clr   = 1'b0;
        #2;
        chk("rst_busy", {31'b0, busy}, 32'h1);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_faddr", fault_addr, 32'h0);
        chk("rst_rdata", r_data, 32'h0);
        chk("rst_mis", {31'b0, misaligned}, 32'h0);
        #10;
        reset = 1'b0;
        wait_clear(ncyc);
        write_en = 1'b0;
        chk("clear_len", ncyc, 64);

        for (int a = 0; a < 256; a += 4) ld(a, 2'b10, 1'b0, 32'h0);

        st(32'h0, 32'h1122_3344, 2'b10);
        st(32'h1, 32'h0000_00AA, 2'b00);
        st(32'h2, 32'h0000_BEEF, 2'b01);
        ld(32'h0, 2'b10, 1'b0, 32'hBEEF_AA44);
        ld(32'h1, 2'b00, 1'b0, 32'hFFFF_FFAA);
        ld(32'h1, 2'b00, 1'b1, 32'h0000_00AA);
        ld(32'h2, 2'b01, 1'b0, 32'hFFFF_BEEF);
        ld(32'h2, 2'b01, 1'b1, 32'h0000_BEEF);
        ld(32'h0, 2'b00, 1'b0, 32'h0000_0044);
        ld(32'h0, 2'b01, 1'b0, 32'hFFFF_AA44);
        ld(32'h3, 2'b00, 1'b1, 32'h0000_00BE);

        addr     = 32'h6;
        w_data   = 32'hDEAD_BEEF;
        size     = 2'b10;
        write_en = 1'b1;
        @(negedge clk);
        chk("mis_sw6", {31'b0, misaligned}, 32'h1);
        chk("mis_rd0", r_data, 32'h0);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        chk("fault_set", {31'b0, fault}, 32'h1);
        chk("faddr_6", fault_addr, 32'h6);
        ld(32'h4, 2'b10, 1'b0, 32'h0);

        addr     = 32'h3;
        size     = 2'b01;
        write_en = 1'b1;
        @(negedge clk);
        chk("mis_sh3", {31'b0, misaligned}, 32'h1);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        chk("faddr_hold", fault_addr, 32'h6);
        chk("fault_hold", {31'b0, fault}, 32'h1);

        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        chk("fault_clr", {31'b0, fault}, 32'h0);
        ld(32'h8, 2'b10, 1'b0, 32'h0);
        chk("fault_ok", {31'b0, fault}, 32'h0);

        addr      = 32'hA;
        size      = 2'b10;
        read_en   = 1'b1;
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_wins", {31'b0, fault}, 32'h0);
        fault_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("fault_again", {31'b0, fault}, 32'h1);
        chk("faddr_A", fault_addr, 32'hA);
        read_en   = 1'b0;
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;

        st(32'h100, 32'h5A5A_5A5A, 2'b10);
        ld(32'h0, 2'b10, 1'b0, 32'h5A5A_5A5A);
        addr     = 32'h0;
        w_data   = 32'h0;
        size     = 2'b11;
        write_en = 1'b1;
        @(negedge clk);
        chk("mis_sz11", {31'b0, misaligned}, 32'h1);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        ld(32'h0, 2'b10, 1'b0, 32'h5A5A_5A5A);
        ld(32'h0, 2'b11, 1'b0, 32'h0);

        st(32'hC8, 32'h1234_5678, 2'b10);
        st(32'hFC, 32'hCAFE_F00D, 2'b10);
        ld(32'hC8, 2'b10, 1'b0, 32'h1234_5678);
        ld(32'hFC, 2'b10, 1'b0, 32'hCAFE_F00D);
        reset = 1'b1;
        #2;
        chk("arst_busy", {31'b0, busy}, 32'h1);
        chk("arst_fault", {31'b0, fault}, 32'h0);
        chk("arst_faddr", fault_addr, 32'h0);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        wait_clear(ncyc);
        chk("reclear_len", ncyc, 64);
        ld(32'h0, 2'b10, 1'b0, 32'h0);
        ld(32'hC8, 2'b10, 1'b0, 32'h0);
        ld(32'hFC, 2'b10, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
